// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter: shares one single-port memory bus between the instruction-fetch
// path and the data (load/store) path. One transaction is outstanding at a time:
// arbitrate in IDLE, present the registered request in REQ until the memory grants,
// then wait in RESP for the response and route it back to the owning requester.
// Data has priority. A starvation guard forces a fetch grant after STARVE_LIMIT
// consecutive data grants taken while fetch was waiting.
//
// Ports:
//   i_clk, i_rst_n                      clock, asynchronous active-low reset
//   i_if_req/i_if_addr                  fetch request and address
//   o_if_gnt                            fetch accepted this cycle (combinational)
//   o_if_rvalid/o_if_rdata              fetch response pulse and held read data
//   i_d_req/i_d_we/i_d_be/i_d_addr/i_d_wdata  data request and payload
//   o_d_gnt                             data accepted this cycle (combinational)
//   o_d_rvalid/o_d_rdata                data response pulse and held data (0 for stores)
//   o_mem_req/o_mem_we/o_mem_be/o_mem_addr/o_mem_wdata  registered memory request
//   i_mem_gnt, i_mem_rvalid, i_mem_rdata                memory handshake and response
//   o_busy                              a transaction is outstanding
module cpu_mem_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_if_req,
  input  logic [ADDR_W-1:0]   i_if_addr,
  output logic                o_if_gnt,
  output logic                o_if_rvalid,
  output logic [DATA_W-1:0]   o_if_rdata,
  input  logic                i_d_req,
  input  logic                i_d_we,
  input  logic [DATA_W/8-1:0] i_d_be,
  input  logic [ADDR_W-1:0]   i_d_addr,
  input  logic [DATA_W-1:0]   i_d_wdata,
  output logic                o_d_gnt,
  output logic                o_d_rvalid,
  output logic [DATA_W-1:0]   o_d_rdata,
  output logic                o_mem_req,
  output logic                o_mem_we,
  output logic [DATA_W/8-1:0] o_mem_be,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic [DATA_W-1:0]   o_mem_wdata,
  input  logic                i_mem_gnt,
  input  logic                i_mem_rvalid,
  input  logic [DATA_W-1:0]   i_mem_rdata,
  output logic                o_busy
);

  localparam int unsigned BeW     = DATA_W / 8;
  localparam int unsigned StreakW = $clog2(STARVE_LIMIT + 1);
  localparam logic [StreakW-1:0] StreakMax = StreakW'(STARVE_LIMIT);

  typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

  state_e              state_q;
  logic                owner_d_q;  // 1: data owns the transaction, 0: fetch
  logic                store_q;    // outstanding data access is a store
  logic [StreakW-1:0]  streak_q;

  logic                mem_req_q;
  logic                mem_we_q;
  logic [BeW-1:0]      mem_be_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic                if_rvalid_q;
  logic [DATA_W-1:0]   if_rdata_q;
  logic                d_rvalid_q;
  logic [DATA_W-1:0]   d_rdata_q;

  logic idle;
  logic starved;
  logic if_gnt;
  logic d_gnt;

  assign idle    = (state_q == StIdle);
  assign starved = (streak_q == StreakMax);

  // Data wins a tie unless fetch has been passed over STARVE_LIMIT times in a row.
  assign if_gnt = idle & i_if_req & (~i_d_req | starved);
  assign d_gnt  = idle & i_d_req & ~(i_if_req & starved);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= StIdle;
      owner_d_q   <= 1'b0;
      store_q     <= 1'b0;
      streak_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      d_rvalid_q  <= 1'b0;
      d_rdata_q   <= '0;
    end else begin
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (d_gnt) begin
            state_q     <= StReq;
            owner_d_q   <= 1'b1;
            store_q     <= i_d_we;
            mem_req_q   <= 1'b1;
            mem_we_q    <= i_d_we;
            mem_be_q    <= i_d_be;
            mem_addr_q  <= i_d_addr;
            mem_wdata_q <= i_d_wdata;
            // Count only grants that actually held fetch off.
            if (!i_if_req) begin
              streak_q <= '0;
            end else if (!starved) begin
              streak_q <= streak_q + StreakW'(1);
            end
          end else if (if_gnt) begin
            state_q     <= StReq;
            owner_d_q   <= 1'b0;
            store_q     <= 1'b0;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '1;
            mem_addr_q  <= i_if_addr;
            mem_wdata_q <= '0;
            streak_q    <= '0;
          end
        end
        StReq: begin
          if (i_mem_gnt) begin
            state_q     <= StResp;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
          end
        end
        StResp: begin
          if (i_mem_rvalid) begin
            state_q <= StIdle;
            if (owner_d_q) begin
              d_rvalid_q <= 1'b1;
              d_rdata_q  <= store_q ? '0 : i_mem_rdata;
            end else begin
              if_rvalid_q <= 1'b1;
              if_rdata_q  <= i_mem_rdata;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Grants are combinational; mask them while reset is asserted so every output is 0.
  assign o_if_gnt    = if_gnt & i_rst_n;
  assign o_d_gnt     = d_gnt & i_rst_n;
  assign o_if_rvalid = if_rvalid_q;
  assign o_if_rdata  = if_rdata_q;
  assign o_d_rvalid  = d_rvalid_q;
  assign o_d_rdata   = d_rdata_q;
  assign o_mem_req   = mem_req_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_be    = mem_be_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_busy      = ~idle;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
module tb_cpu_mem_arbiter;
  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned LIM = 4;

  logic          i_clk, i_rst_n;
  logic          i_if_req;
  logic [AW-1:0] i_if_addr;
  logic          o_if_gnt, o_if_rvalid;
  logic [DW-1:0] o_if_rdata;
  logic          i_d_req, i_d_we;
  logic [3:0]    i_d_be;
  logic [AW-1:0] i_d_addr;
  logic [DW-1:0] i_d_wdata;
  logic          o_d_gnt, o_d_rvalid;
  logic [DW-1:0] o_d_rdata;
  logic          o_mem_req, o_mem_we;
  logic [3:0]    o_mem_be;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] o_mem_wdata;
  logic          i_mem_gnt, i_mem_rvalid;
  logic [DW-1:0] i_mem_rdata;
  logic          o_busy;

  cpu_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr), .o_if_gnt(o_if_gnt),
    .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
    .i_d_req(i_d_req), .i_d_we(i_d_we), .i_d_be(i_d_be), .i_d_addr(i_d_addr),
    .i_d_wdata(i_d_wdata), .o_d_gnt(o_d_gnt), .o_d_rvalid(o_d_rvalid), .o_d_rdata(o_d_rdata),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_be(o_mem_be), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .i_mem_gnt(i_mem_gnt), .i_mem_rvalid(i_mem_rvalid),
    .i_mem_rdata(i_mem_rdata), .o_busy(o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_err    = 0;

  // Requester intent, applied to the DUT inputs just after each rising edge.
  logic          s_if_req, s_d_req, s_d_we;
  logic [AW-1:0] s_if_addr, s_d_addr;
  logic [3:0]    s_d_be;
  logic [DW-1:0] s_d_wdata;

  // Transaction-level reference: each grant fixes the cycles of memory grant and
  // response, from which every expected output is derived arithmetically.
  int            cyc;
  bit            t_act, t_own_d, t_we;
  int            t_gnt, t_mg, t_rv;
  logic [3:0]    t_be;
  logic [AW-1:0] t_addr;
  logic [DW-1:0] t_wdata, t_rdata;
  int            m_streak;
  logic [DW-1:0] m_if_rdata, m_d_rdata;
  int            gw_cfg, rw_cfg;       // memory wait cycles, -1 = random
  logic [DW-1:0] force_rdata;          // 0 = random read data
  bit            log_q[$];             // grant owners, 1 = data
  bit            exp_pat [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    bit resp, idle, mreq_e, eg_if, eg_d;
    int gw, rw;
    @(posedge i_clk);
    #1;
    cyc++;
    i_if_req  = s_if_req;  i_if_addr = s_if_addr;
    i_d_req   = s_d_req;   i_d_we    = s_d_we;    i_d_be = s_d_be;
    i_d_addr  = s_d_addr;  i_d_wdata = s_d_wdata;
    i_mem_gnt    = t_act && (cyc == t_mg);
    i_mem_rvalid = t_act && (cyc == t_rv);
    i_mem_rdata  = (force_rdata != '0) ? force_rdata : ($urandom | 32'h1);
    if (i_mem_rvalid) t_rdata = i_mem_rdata;
    #1;
    resp   = t_act && (cyc == t_rv + 1);
    idle   = !t_act || (cyc > t_rv);
    mreq_e = t_act && (cyc > t_gnt) && (cyc <= t_mg);
    if (resp) begin
      if (t_own_d) m_d_rdata = t_we ? '0 : t_rdata;
      else         m_if_rdata = t_rdata;
      t_act = 1'b0;
    end
    chk("busy", 128'(o_busy), 128'(!idle));
    chk("mem_req", 128'(o_mem_req), 128'(mreq_e));
    if (mreq_e && t_own_d)
      chk("mem_payload_d", {o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata},
          {t_we, t_be, t_addr, t_wdata});
    else if (mreq_e)
      chk("mem_payload_if", {o_mem_we, o_mem_be, o_mem_addr}, {1'b0, 4'hF, t_addr});
    else
      chk("mem_payload_idle", {o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata}, 128'h0);
    chk("rvalid", {o_if_rvalid, o_d_rvalid}, {resp && !t_own_d, resp && t_own_d});
    chk("rdata", {o_if_rdata, o_d_rdata}, {m_if_rdata, m_d_rdata});
    eg_if = idle && i_if_req && (!i_d_req || m_streak == LIM);
    eg_d  = idle && i_d_req && !eg_if;
    chk("gnt", {o_if_gnt, o_d_gnt}, {eg_if, eg_d});
    if (eg_if || eg_d) begin
      gw = (gw_cfg < 0) ? int'($urandom_range(0, 2)) : gw_cfg;
      rw = (rw_cfg < 0) ? int'($urandom_range(0, 2)) : rw_cfg;
      t_act = 1'b1; t_gnt = cyc; t_own_d = eg_d;
      t_mg  = cyc + 1 + gw;
      t_rv  = t_mg + 1 + rw;
      if (eg_d) begin
        t_we = i_d_we; t_be = i_d_be; t_addr = i_d_addr; t_wdata = i_d_wdata;
        m_streak = i_if_req ? ((m_streak < LIM) ? m_streak + 1 : LIM) : 0;
        s_d_req = 1'b0;
      end else begin
        t_we = 1'b0; t_be = 4'hF; t_addr = i_if_addr; t_wdata = '0;
        m_streak = 0;
        s_if_req = 1'b0;
      end
      log_q.push_back(eg_d);
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && (s_if_req || s_d_req || t_act); k++) cycle();
  endtask

  initial begin
    int g, cnt, pulses;
    s_if_req = 0; s_d_req = 0; s_d_we = 0; s_if_addr = '0; s_d_addr = '0;
    s_d_be = '0; s_d_wdata = '0;
    i_if_req = 0; i_if_addr = '0; i_d_req = 0; i_d_we = 0; i_d_be = '0; i_d_addr = '0;
    i_d_wdata = '0; i_mem_gnt = 0; i_mem_rvalid = 0; i_mem_rdata = '0;
    cyc = 0; t_act = 0; t_gnt = 0; t_mg = 0; t_rv = 0; t_own_d = 0; t_we = 0;
    t_be = '0; t_addr = '0; t_wdata = '0; t_rdata = '0;
    m_streak = 0; m_if_rdata = '0; m_d_rdata = '0;
    gw_cfg = 0; rw_cfg = 0; force_rdata = '0;

    // Reset state
    i_rst_n = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    chk("reset_outs", {o_if_gnt, o_d_gnt, o_if_rvalid, o_d_rvalid, o_busy, o_mem_req,
                       o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata}, 128'h0);
    chk("reset_rdata", {o_if_rdata, o_d_rdata}, 128'h0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // Single fetch, immediate memory
    force_rdata = 32'h00500093;
    s_if_req = 1; s_if_addr = 32'h40;
    cycle();
    chk("fetch_gnt_c0", 128'(o_if_gnt), 128'(1'b1));
    cycle();
    chk("fetch_mem_c1", {o_mem_req, o_mem_we, o_mem_be, o_mem_addr}, {1'b1, 1'b0, 4'hF, 32'h40});
    cycle();
    cycle();
    chk("fetch_resp_c3", {o_if_rvalid, o_d_rvalid, o_if_rdata}, {2'b10, 32'h00500093});

    // Store with a 2-cycle memory grant delay
    force_rdata = 32'h12345678;
    gw_cfg = 2;
    s_d_req = 1; s_d_we = 1; s_d_be = 4'h3; s_d_addr = 32'h104; s_d_wdata = 32'hDEADBEEF;
    cycle();
    cnt = 0; pulses = 0;
    for (int k = 0; k < 8; k++) begin
      cycle();
      cnt += int'(o_mem_req);
      pulses += int'(o_d_rvalid);
      if (o_d_rvalid) chk("store_rdata", 128'(o_d_rdata), 128'h0);
    end
    chk("store_req_cycles", 128'(cnt), 128'(3));
    chk("store_pulses", 128'(pulses), 128'(1));

    // Both requesters held: fetch wins every fifth grant
    force_rdata = '0; gw_cfg = 0;
    log_q.delete();
    for (int k = 0; k < 80 && log_q.size() < 10; k++) begin
      if (!s_if_req) begin s_if_req = 1; s_if_addr = 32'h1000 + 32'(k * 4); end
      if (!s_d_req) begin
        s_d_req = 1; s_d_we = 0; s_d_be = 4'hF; s_d_addr = 32'h2000 + 32'(k * 4); s_d_wdata = '0;
      end
      cycle();
      if (o_if_gnt) chk("streak_at_if", 128'(dut.streak_q), 128'(LIM));
    end
    chk("starve_count", 128'(log_q.size()), 128'(10));
    for (int k = 0; k < 10 && k < log_q.size(); k++)
      chk($sformatf("starve_seq%0d", k), 128'(log_q[k]), 128'(exp_pat[k]));
    drain();

    // Data request blocked while a fetch is outstanding
    gw_cfg = 1; rw_cfg = 1;
    s_if_req = 1; s_if_addr = 32'h300;
    cycle();
    g = cyc;
    s_d_req = 1; s_d_we = 0; s_d_be = 4'hF; s_d_addr = 32'h400; s_d_wdata = '0;
    for (int k = 0; k < 10; k++) begin
      cycle();
      if (o_d_gnt) break;
    end
    chk("blk_gnt_idle", {o_d_gnt, o_busy}, 2'b10);
    chk("blk_wait", 128'(cyc - g), 128'(5));
    cycle();
    chk("blk_payload", {o_mem_req, o_mem_addr}, {1'b1, 32'h400});
    drain();

    // Back-to-back: fetch response and data grant in the same cycle
    gw_cfg = 0; rw_cfg = 0;
    s_if_req = 1; s_if_addr = 32'h500;
    cycle();
    s_d_req = 1; s_d_we = 0; s_d_be = 4'hF; s_d_addr = 32'h600; s_d_wdata = '0;
    cycle(); cycle(); cycle();
    chk("b2b_c3", {o_if_rvalid, o_d_gnt}, 2'b11);
    cycle();
    chk("b2b_c4", {o_mem_req, o_mem_addr}, {1'b1, 32'h600});
    drain();

    // Asynchronous reset while waiting for the response
    gw_cfg = 1; rw_cfg = 3;
    s_if_req = 1; s_if_addr = 32'h80;
    cycle();
    for (int k = 0; k < 10 && !(t_act && cyc > t_mg); k++) cycle();
    #1;
    i_if_req = 1'b1;
    i_rst_n  = 1'b0;
    #1;
    chk("rst_mid_outs", {o_if_gnt, o_d_gnt, o_if_rvalid, o_d_rvalid, o_busy, o_mem_req,
                         o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata}, 128'h0);
    chk("rst_mid_rdata", {o_if_rdata, o_d_rdata}, 128'h0);
    @(posedge i_clk);
    #1;
    chk("rst_hold", {o_if_gnt, o_if_rvalid, o_d_rvalid, o_busy, o_mem_req}, 128'h0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    i_if_req = 1'b0; i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0;
    t_act = 0; m_streak = 0; m_if_rdata = '0; m_d_rdata = '0; s_if_req = 0; s_d_req = 0;
    gw_cfg = 0; rw_cfg = 0; force_rdata = 32'hCAFE0001;
    s_if_req = 1; s_if_addr = 32'h200;
    cycle();
    chk("post_rst_gnt", 128'(o_if_gnt), 128'(1'b1));
    repeat (3) cycle();
    chk("post_rst_resp", {o_if_rvalid, o_if_rdata}, {1'b1, 32'hCAFE0001});

    // Randomized traffic against the reference
    force_rdata = '0; gw_cfg = -1; rw_cfg = -1;
    for (int k = 0; k < 600; k++) begin
      if (!s_if_req && $urandom_range(0, 3) != 0) begin
        s_if_req = 1; s_if_addr = $urandom;
      end
      if (!s_d_req && $urandom_range(0, 3) != 0) begin
        s_d_req = 1; s_d_we = 1'($urandom_range(0, 1)); s_d_be = 4'($urandom_range(0, 15));
        s_d_addr = $urandom; s_d_wdata = $urandom;
      end
      cycle();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/cpu_mem_arbiter.md
# cpu_mem_arbiter

Two-requester arbiter that shares one single-port memory bus between the instruction-fetch path and the data (load/store) path of the 5-stage core. It accepts one transaction at a time, forwards it to the memory with a request/grant handshake, waits for the response and routes it back to the owning requester. Data accesses have priority, and a starvation guard bounds how long fetch can be held off.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width; byte enables are `DATA_W/8` bits.
- `STARVE_LIMIT`, default 4: maximum number of consecutive data grants while fetch is waiting. Legal range is 1 or more.

Ports:
- `i_clk`  in  1: the single clock; everything is on the rising edge.
- `i_rst_n`  in  1: asynchronous, active-low reset.
- `i_if_req`  in  1: fetch request. Held with its address until granted.
- `i_if_addr`  in  ADDR_W: fetch address.
- `o_if_gnt`  out  1: fetch request accepted this cycle (combinational).
- `o_if_rvalid`  out  1: one-cycle pulse; fetch response valid.
- `o_if_rdata`  out  DATA_W: fetch read data.
- `i_d_req`  in  1: data request. Held with its payload until granted.
- `i_d_we`  in  1: 1 = store, 0 = load.
- `i_d_be`  in  DATA_W/8: byte enables.
- `i_d_addr`  in  ADDR_W: data address.
- `i_d_wdata`  in  DATA_W: store data.
- `o_d_gnt`  out  1: data request accepted this cycle (combinational).
- `o_d_rvalid`  out  1: one-cycle pulse; data response valid (loads and stores).
- `o_d_rdata`  out  DATA_W: load data; 0 for stores.
- `o_mem_req`  out  1: memory request, held until `i_mem_gnt`.
- `o_mem_we`, `o_mem_be`, `o_mem_addr`, `o_mem_wdata`  out: registered request payload. Fetches always drive we=0 and be=all-ones.
- `i_mem_gnt`  in  1: memory accepted the request.
- `i_mem_rvalid`  in  1: memory response valid.
- `i_mem_rdata`  in  DATA_W: memory read data.
- `o_busy`  out  1: a transaction is outstanding (state != IDLE).

## Operation

**States**

IDLE:
- Arbitration is combinational on `i_if_req` and `i_d_req`.
- Only one requester is asserting: grant it.
- Both are asserting: grant data, unless `streak == STARVE_LIMIT`, in which case grant fetch.
- On a grant:
  - pulse the matching `o_*_gnt`;
  - at the clock edge, capture the payload into `o_mem_*` and record the owner (IF or D);
  - move to REQ.
- No requester is asserting: stay in IDLE.

REQ:
- `o_mem_req` = 1 and the payload is held stable.
- Move to RESP on the edge where `i_mem_gnt` = 1.
- On that same edge, deassert `o_mem_req` and zero the `o_mem_*` payload.

RESP:
- Wait for `i_mem_rvalid`.
- On the edge where it is 1:
  - register the response to the owner: set that owner's `o_*_rvalid`, and load its `o_*_rdata` with `i_mem_rdata`, or with 0 for a store;
  - go to IDLE.
- `o_*_rvalid` is cleared after one cycle.
- `o_*_rdata` holds its value until the next response to that port.

Requests arriving outside IDLE get no grant. The requester keeps `req` and its payload asserted; the payload may change only after the gnt cycle.

**Starvation counter `streak`**
- Width is `$clog2(STARVE_LIMIT+1)`.
- Data grant with `i_if_req` = 1: `streak` += 1, saturating at `STARVE_LIMIT`.
- Data grant with `i_if_req` = 0: `streak` is cleared.
- Any fetch grant: `streak` is cleared.

**Protocol rules** (checked by bench assertions; the RTL has no obligation for these cases)
- `i_mem_rvalid` outside RESP is ignored.
- `i_mem_rvalid` arrives no earlier than the cycle after `i_mem_gnt`.
- Addresses pass through unchecked; alignment is the requester's responsibility.

## Timing

**Reset**
- Async assertion forces state = IDLE and `streak` = 0.
- All outputs go to 0: `o_mem_*`, `o_*_gnt`, `o_*_rvalid`, `o_*_rdata`, `o_busy`.
- Reset mid-transaction drops the transaction silently, with no response. The memory bus must be reset together with the arbiter.

**Latency** (request seen in IDLE at cycle 0)
- Cycle 0: `o_x_gnt` = 1.
- Cycle 1: `o_mem_req` = 1. If `i_mem_gnt` = 1 in cycle 1 and `i_mem_rvalid` = 1 in cycle 2, then `o_x_rvalid` = 1 in cycle 3.
- The state is IDLE again in cycle 3, so a new grant is possible in cycle 3.
- Minimum spacing between grants is 3 cycles.
- Each wait cycle on `i_mem_gnt` or `i_mem_rvalid` adds 1 cycle.

**Simultaneous events**
- The rvalid pulse for transaction N and the gnt for transaction N+1 can occur in the same cycle.
- `o_busy` is 1 from cycle 1 through the response edge, and 0 in the rvalid cycle.

## Test plan
- **Single fetch.** `i_if_req`=1, addr=0x40; memory gnt is immediate, rvalid one cycle later with rdata=0x00500093.
  - `o_if_gnt` in cycle 0.
  - `o_mem_req`=1, addr=0x40, we=0, be=0xF in cycle 1.
  - `o_if_rvalid`=1, rdata=0x00500093 in cycle 3.
  - `o_d_rvalid` stays 0.
- **Store.** we=1, be=0x3, addr=0x104, wdata=0xDEADBEEF; memory gnt is delayed 2 cycles.
  - `o_mem_req` is held for 3 cycles with a stable payload.
  - `o_d_rvalid` pulses once, with rdata=0.
- **Simultaneous requests, STARVE_LIMIT=4.** `i_if_req` and `i_d_req` held high continuously.
  - The grant sequence is D, D, D, D, IF, D, D, D, D, IF.
  - `streak` reads 4 at each IF grant.
- **Busy blocking.** `i_d_req` is raised while in REQ/RESP for an outstanding fetch.
  - `o_d_gnt` stays 0 until IDLE.
  - It is then granted with the payload presented at that moment.
- **Back-to-back.** Fetch response and a pending data request meet in cycle 3.
  - `o_if_rvalid` and `o_d_gnt` are both 1 in cycle 3.
  - `o_mem_req` for data is 1 in cycle 4.
- **Reset mid-transaction.** `i_rst_n` is dropped asynchronously in RESP.
  - All outputs are 0 immediately, `o_busy`=0, and there is no rvalid.
  - After release, a new fetch completes with the normal 3-cycle latency.
